// File: rtl/bbox_tracker.sv
// ---------------------------------------------------------------------------
// bbox_tracker
//
// Purpose:
//   Tracks the bounding box of "dark" pixels inside a programmable region of
//   interest over one video frame. When the frame closes, the box is widened
//   by MARGIN on every side, clamped to the frame, and published together with
//   a one-cycle box_valid strobe. Frames with no dark pixel keep the old box
//   and report box_found = 0.
//
//   Three register stages:
//     stage 1 : hit decision, coordinates and frame flags
//     stage 2 : min/max accumulators and hit flag
//     output  : margin-expanded, clamped box and strobe
//
// Optional feature (macro BBOX_PIXCNT_EN):
//   Adds output pix_count, which reports the number of hit pixels in the
//   closed frame. The count saturates at all-ones.
//
// Ports:
//   clk, rst_n               pixel clock, asynchronous active-low reset
//   pix_valid                pixel qualifier
//   pix_data [DW-1:0]        RGB pixel, channel at [CH_LSB+7:CH_LSB]
//   pix_x / pix_y            pixel column / row
//   frame_start, frame_end   first / last pixel of a frame (with pix_valid)
//   roi_left/right/top/bottom  ROI, exclusive bounds, sampled at frame_start
//   box_left/right/top/bottom  published box
//   box_found                last closed frame contained a dark pixel
//   box_valid                one-cycle strobe when the box_* outputs update
//   pix_count                hit pixel count (BBOX_PIXCNT_EN only)
// ---------------------------------------------------------------------------
module bbox_tracker #(
    parameter int XW      = 11,
    parameter int YW      = 10,
    parameter int DW      = 24,
    parameter int CH_LSB  = 0,
    parameter int THRESH  = 200,
    parameter int MARGIN  = 15,
    parameter int FRAME_W = 1280,
    parameter int FRAME_H = 720
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [DW-1:0]     pix_data,
    input  logic [XW-1:0]     pix_x,
    input  logic [YW-1:0]     pix_y,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic [XW-1:0]     roi_left,
    input  logic [XW-1:0]     roi_right,
    input  logic [YW-1:0]     roi_top,
    input  logic [YW-1:0]     roi_bottom,
    output logic [XW-1:0]     box_left,
    output logic [XW-1:0]     box_right,
    output logic [YW-1:0]     box_top,
    output logic [YW-1:0]     box_bottom,
    output logic              box_found,
    output logic              box_valid
`ifdef BBOX_PIXCNT_EN
    ,
    output logic [XW+YW-1:0]  pix_count
`endif
);

    localparam logic [7:0]    THRESH_C  = 8'(THRESH);
    localparam logic [XW-1:0] X_MAX     = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(FRAME_H - 1);
    localparam logic [XW:0]   X_MAX_W   = (XW+1)'(FRAME_W - 1);
    localparam logic [YW:0]   Y_MAX_W   = (YW+1)'(FRAME_H - 1);
    localparam logic [XW:0]   MARGIN_XW = (XW+1)'(MARGIN);
    localparam logic [YW:0]   MARGIN_YW = (YW+1)'(MARGIN);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t state_q, state_d;
    // open_q separates "inside a frame" from "closed, waiting for the next
    // frame_start" while the FSM sits in SCAN.
    logic open_q, open_d;
    logic accept;

    logic [XW-1:0] roi_left_q, roi_right_q;
    logic [YW-1:0] roi_top_q, roi_bottom_q;
    logic [XW-1:0] eff_left, eff_right;
    logic [YW-1:0] eff_top, eff_bottom;
    logic          is_dark, in_roi;

    logic          s1_valid_q, s1_hit_q, s1_start_q, s1_end_q;
    logic [XW-1:0] s1_x_q;
    logic [YW-1:0] s1_y_q;

    logic [XW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [YW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic          hit_q, hit_d;
    logic          close_q;

    logic [XW:0]   lo_x_w, hi_x_w;
    logic [YW:0]   lo_y_w, hi_y_w;
    logic [XW-1:0] new_left, new_right;
    logic [YW-1:0] new_top, new_bottom;

    logic [XW-1:0] box_left_q, box_right_q;
    logic [YW-1:0] box_top_q, box_bottom_q;
    logic          box_found_q, box_valid_q;

    // Only the threshold channel matters; the other colour bits are consumed
    // here so they do not look like forgotten wiring.
    logic unused_pix_data;
    assign unused_pix_data = ^pix_data;

    // A pixel enters the pipeline if it opens a frame or arrives while one is
    // open. Pixels in IDLE or after a close are dropped here.
    assign accept = pix_valid && (frame_start || (state_q == SCAN && open_q));

    // Next state and frame-open tracking. A pixel carrying both flags opens
    // and closes a frame in one go, so open_d follows frame_end.
    always_comb begin
        state_d = state_q;
        open_d  = open_q;
        if (pix_valid && frame_start) begin
            state_d = SCAN;
        end
        if (accept) begin
            open_d = !frame_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            open_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            open_q  <= open_d;
        end
    end

    // The frame_start pixel must be judged against the ROI being sampled on
    // that same cycle, so the live inputs bypass the shadow registers then.
    always_comb begin
        eff_left   = roi_left_q;
        eff_right  = roi_right_q;
        eff_top    = roi_top_q;
        eff_bottom = roi_bottom_q;
        if (frame_start) begin
            eff_left   = roi_left;
            eff_right  = roi_right;
            eff_top    = roi_top;
            eff_bottom = roi_bottom;
        end
    end

    assign is_dark = pix_data[CH_LSB +: 8] < THRESH_C;
    assign in_roi  = (pix_x > eff_left) && (pix_x < eff_right) &&
                     (pix_y > eff_top)  && (pix_y < eff_bottom);

    // ROI shadow registers, refreshed only on the frame_start pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            roi_left_q   <= '0;
            roi_right_q  <= '0;
            roi_top_q    <= '0;
            roi_bottom_q <= '0;
        end else if (pix_valid && frame_start) begin
            roi_left_q   <= roi_left;
            roi_right_q  <= roi_right;
            roi_top_q    <= roi_top;
            roi_bottom_q <= roi_bottom;
        end
    end

    // Stage 1: register the per-pixel decision and frame flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_start_q <= 1'b0;
            s1_end_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            s1_hit_q   <= accept && is_dark && in_roi;
            s1_start_q <= accept && frame_start;
            s1_end_q   <= accept && frame_end;
            s1_x_q     <= pix_x;
            s1_y_q     <= pix_y;
        end
    end

    // Stage 2 next-state: a frame_start pixel reinitialises the accumulators
    // before its own contribution is applied, which also discards any
    // aborted frame.
    always_comb begin
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
        hit_d   = hit_q;
        if (s1_valid_q) begin
            if (s1_start_q) begin
                min_x_d = '1;
                max_x_d = '0;
                min_y_d = '1;
                max_y_d = '0;
                hit_d   = 1'b0;
            end
            if (s1_hit_q) begin
                if (s1_x_q < min_x_d) min_x_d = s1_x_q;
                if (s1_x_q > max_x_d) max_x_d = s1_x_q;
                if (s1_y_q < min_y_d) min_y_d = s1_y_q;
                if (s1_y_q > max_y_d) max_y_d = s1_y_q;
                hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_x_q <= '1;
            max_x_q <= '0;
            min_y_q <= '1;
            max_y_q <= '0;
            hit_q   <= 1'b0;
            close_q <= 1'b0;
        end else begin
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
            hit_q   <= hit_d;
            close_q <= s1_valid_q && s1_end_q;
        end
    end

    // Margin arithmetic one bit wider than the coordinate. The extra MSB of
    // the difference is the borrow, meaning min < MARGIN, so clamp to 0.
    always_comb begin
        lo_x_w     = {1'b0, min_x_q} - MARGIN_XW;
        hi_x_w     = {1'b0, max_x_q} + MARGIN_XW;
        lo_y_w     = {1'b0, min_y_q} - MARGIN_YW;
        hi_y_w     = {1'b0, max_y_q} + MARGIN_YW;
        new_left   = lo_x_w[XW] ? '0 : lo_x_w[XW-1:0];
        new_top    = lo_y_w[YW] ? '0 : lo_y_w[YW-1:0];
        new_right  = (hi_x_w > X_MAX_W) ? X_MAX : hi_x_w[XW-1:0];
        new_bottom = (hi_y_w > Y_MAX_W) ? Y_MAX : hi_y_w[YW-1:0];
    end

    // Output stage: publish on close. An empty frame keeps the previous box
    // but still strobes with box_found low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_left_q   <= '0;
            box_right_q  <= X_MAX;
            box_top_q    <= '0;
            box_bottom_q <= Y_MAX;
            box_found_q  <= 1'b0;
            box_valid_q  <= 1'b0;
        end else begin
            box_valid_q <= close_q;
            if (close_q) begin
                box_found_q <= hit_q;
                if (hit_q) begin
                    box_left_q   <= new_left;
                    box_right_q  <= new_right;
                    box_top_q    <= new_top;
                    box_bottom_q <= new_bottom;
                end
            end
        end
    end

    assign box_left   = box_left_q;
    assign box_right  = box_right_q;
    assign box_top    = box_top_q;
    assign box_bottom = box_bottom_q;
    assign box_found  = box_found_q;
    assign box_valid  = box_valid_q;

`ifdef BBOX_PIXCNT_EN
    logic [XW+YW-1:0] cnt_q, cnt_d, pix_count_q;

    // Hit counter running alongside the stage 2 accumulators.
    always_comb begin
        cnt_d = cnt_q;
        if (s1_valid_q) begin
            if (s1_start_q) begin
                cnt_d = '0;
            end
            if (s1_hit_q && (cnt_d != '1)) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pix_count_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (close_q) begin
                pix_count_q <= cnt_q;
            end
        end
    end

    assign pix_count = pix_count_q;
`endif

endmodule

// File: tb/tb_bbox_tracker.sv
// ---------------------------------------------------------------------------
// tb_bbox_tracker
//
// Directed bench for bbox_tracker with default parameters. Frames are sparse:
// only the pixels of interest are sent, flagged with frame_start/frame_end.
// Expected boxes are worked out by hand from MARGIN = 15 and the 1280x720
// frame. Build with BBOX_PIXCNT_EN defined to include the pixel-count case.
// ---------------------------------------------------------------------------
module tb_bbox_tracker;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int DW = 24;
    localparam logic [7:0] DARK = 8'h10;
    localparam logic [7:0] BG   = 8'hFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          frame_start;
    logic          frame_end;
    logic [XW-1:0] roi_left, roi_right;
    logic [YW-1:0] roi_top, roi_bottom;
    logic [XW-1:0] box_left, box_right;
    logic [YW-1:0] box_top, box_bottom;
    logic          box_found;
    logic          box_valid;
`ifdef BBOX_PIXCNT_EN
    logic [XW+YW-1:0] pix_count;
`endif

    int compared    = 0;
    int mismatched  = 0;
    int valid_count = 0;
    int vc0;

    always #5 clk = ~clk;

    // Counts every box_valid strobe, so "no strobe" windows can be checked.
    always @(posedge clk) begin
        if (box_valid === 1'b1) valid_count++;
    end

    bbox_tracker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .roi_left    (roi_left),
        .roi_right   (roi_right),
        .roi_top     (roi_top),
        .roi_bottom  (roi_bottom),
        .box_left    (box_left),
        .box_right   (box_right),
        .box_top     (box_top),
        .box_bottom  (box_bottom),
        .box_found   (box_found),
        .box_valid   (box_valid)
`ifdef BBOX_PIXCNT_EN
        ,
        .pix_count   (pix_count)
`endif
    );

    // Drives one valid pixel for one clock edge, then returns to a bubble
    // 1 ns after that edge.
    task automatic applyStimulus(input int x, input int y, input logic [7:0] ch,
                                 input logic fs, input logic fe);
        pix_valid   = 1'b1;
        pix_x       = XW'(x);
        pix_y       = YW'(y);
        pix_data    = {16'hFFFF, ch};
        frame_start = fs;
        frame_end   = fe;
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pix_data    = '1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkBox(input string tag, input int l, input int r,
                            input int t, input int b, input int found);
        checkOutput({tag, "_left"},   32'(box_left),   32'(l));
        checkOutput({tag, "_right"},  32'(box_right),  32'(r));
        checkOutput({tag, "_top"},    32'(box_top),    32'(t));
        checkOutput({tag, "_bottom"}, 32'(box_bottom), 32'(b));
        checkOutput({tag, "_found"},  32'(box_found),  32'(found));
    endtask

    // Called right after the frame_end pixel edge: strobe must appear after
    // exactly two more edges and last one cycle.
    task automatic closeCheck(input string tag, input int l, input int r,
                              input int t, input int b, input int found);
        checkOutput({tag, "_valid_n0"}, 32'(box_valid), 32'd0);
        idle(1);
        checkOutput({tag, "_valid_n1"}, 32'(box_valid), 32'd0);
        idle(1);
        checkOutput({tag, "_valid_n2"}, 32'(box_valid), 32'd1);
        checkBox(tag, l, r, t, b, found);
        idle(1);
        checkOutput({tag, "_valid_n3"}, 32'(box_valid), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = '1;
        pix_x       = '0;
        pix_y       = '0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        roi_left    = 11'd10;
        roi_right   = 11'd1270;
        roi_top     = 10'd10;
        roi_bottom  = 10'd710;

        // Reset values
        idle(2);
        checkBox("reset", 0, 1279, 0, 719, 0);
        checkOutput("reset_valid", 32'(box_valid), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single blob x 400..500, y 200..300, with bubbles mid-frame
        $display("[TB] single blob");
        applyStimulus(0, 0, BG, 1'b1, 1'b0);
        applyStimulus(400, 200, DARK, 1'b0, 1'b0);
        idle(2);
        applyStimulus(450, 250, DARK, 1'b0, 1'b0);
        applyStimulus(500, 300, DARK, 1'b0, 1'b0);
        applyStimulus(420, 290, DARK, 1'b0, 1'b0);
        vc0 = valid_count;
        applyStimulus(1279, 719, BG, 1'b0, 1'b1);
        closeCheck("blob", 385, 515, 185, 315, 1);
        idle(3);
        checkOutput("blob_one_strobe", 32'(valid_count - vc0), 32'd1);

        // Clamping at both frame edges
        $display("[TB] clamping");
        applyStimulus(12, 12, DARK, 1'b1, 1'b0);
        applyStimulus(1268, 708, DARK, 1'b0, 1'b1);
        closeCheck("clamp", 0, 1279, 0, 719, 1);

        // ROI exclusion: first a real box, then a frame with dark pixels only
        // on or outside the exclusive ROI bounds
        $display("[TB] roi exclusion");
        applyStimulus(400, 200, DARK, 1'b1, 1'b0);
        applyStimulus(500, 300, DARK, 1'b0, 1'b1);
        closeCheck("roi_f1", 385, 515, 185, 315, 1);
        applyStimulus(10, 100, DARK, 1'b1, 1'b0);
        applyStimulus(5, 5, DARK, 1'b0, 1'b0);
        applyStimulus(600, 710, DARK, 1'b0, 1'b0);
        applyStimulus(1270, 300, DARK, 1'b0, 1'b0);
        applyStimulus(700, 10, DARK, 1'b0, 1'b1);
        closeCheck("roi_empty", 385, 515, 185, 315, 0);

        // Abort: second frame_start discards the (300,300) hit
        $display("[TB] abort and threshold");
        vc0 = valid_count;
        applyStimulus(300, 300, DARK, 1'b1, 1'b0);
        applyStimulus(310, 310, DARK, 1'b0, 1'b0);
        applyStimulus(0, 0, BG, 1'b1, 1'b0);
        idle(6);
        checkOutput("abort_no_strobe", 32'(valid_count - vc0), 32'd0);
        applyStimulus(600, 400, 8'd199, 1'b0, 1'b0);
        applyStimulus(601, 400, 8'd200, 1'b0, 1'b0);
        applyStimulus(1279, 719, BG, 1'b0, 1'b1);
        closeCheck("thresh199", 585, 615, 385, 415, 1);
        applyStimulus(600, 400, 8'd200, 1'b1, 1'b0);
        applyStimulus(700, 500, 8'd200, 1'b0, 1'b1);
        closeCheck("thresh200", 585, 615, 385, 415, 0);

        // One-pixel frame
        applyStimulus(800, 600, DARK, 1'b1, 1'b1);
        closeCheck("onepix", 785, 815, 585, 615, 1);

        // Back-to-back: new frame_start on the cycle after frame_end
        $display("[TB] back to back");
        applyStimulus(0, 0, BG, 1'b1, 1'b0);
        applyStimulus(700, 500, DARK, 1'b0, 1'b0);
        applyStimulus(701, 500, DARK, 1'b0, 1'b1);
        checkOutput("b2b_valid_n0", 32'(box_valid), 32'd0);
        applyStimulus(100, 100, DARK, 1'b1, 1'b0);
        checkOutput("b2b_valid_n1", 32'(box_valid), 32'd0);
        idle(1);
        checkOutput("b2b_valid_n2", 32'(box_valid), 32'd1);
        checkBox("b2b_a", 685, 716, 485, 515, 1);
        idle(1);
        checkOutput("b2b_valid_n3", 32'(box_valid), 32'd0);
        applyStimulus(1279, 719, BG, 1'b0, 1'b1);
        closeCheck("b2b_b", 85, 115, 85, 115, 1);

        // Asynchronous reset mid-frame
        $display("[TB] async reset");
        applyStimulus(50, 50, DARK, 1'b1, 1'b0);
        applyStimulus(60, 60, DARK, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkBox("arst", 0, 1279, 0, 719, 0);
        checkOutput("arst_valid", 32'(box_valid), 32'd0);
        idle(2);
        rst_n = 1'b1;
        vc0 = valid_count;
        applyStimulus(70, 70, DARK, 1'b0, 1'b1);
        idle(5);
        checkOutput("arst_idle_no_strobe", 32'(valid_count - vc0), 32'd0);
        checkBox("arst_hold", 0, 1279, 0, 719, 0);
        applyStimulus(200, 100, DARK, 1'b1, 1'b0);
        applyStimulus(210, 110, DARK, 1'b0, 1'b1);
        closeCheck("arst_next", 185, 225, 85, 125, 1);

`ifdef BBOX_PIXCNT_EN
        // 101 x 101 dark square
        $display("[TB] pixel count");
        applyStimulus(0, 0, BG, 1'b1, 1'b0);
        for (int y = 300; y <= 400; y++) begin
            for (int x = 300; x <= 400; x++) begin
                applyStimulus(x, y, DARK, 1'b0, 1'b0);
            end
        end
        applyStimulus(1279, 719, BG, 1'b0, 1'b1);
        closeCheck("pixcnt", 285, 415, 285, 415, 1);
        checkOutput("pixcnt_count", 32'(pix_count), 32'd10201);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
